// File: rtl/r_burst_arbiter_if.sv
// Handshake bundle between NUM_SRC R-channel sources, the burst arbiter and one downstream sink.
// The master modport is the sources-plus-sink side; the arbiter takes the slave modport.
interface r_burst_arbiter_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 14
);
    logic [NUM_SRC*DATA_W-1:0] DATA_IN;
    logic [NUM_SRC-1:0]        LAST_IN;
    logic [NUM_SRC-1:0]        VALID_IN;
    logic [NUM_SRC-1:0]        READY_OUT;
    logic [DATA_W-1:0]         DATA;
    logic                      LAST;
    logic                      VALID;
    logic                      READY;

    modport master (
        output DATA_IN, LAST_IN, VALID_IN, READY,
        input  READY_OUT, DATA, LAST, VALID
    );

    modport slave (
        input  DATA_IN, LAST_IN, VALID_IN, READY,
        output READY_OUT, DATA, LAST, VALID
    );
endinterface

// File: rtl/r_burst_arbiter.sv
// Burst-locked round-robin arbiter: one source owns the R return path from its first beat
// through LAST (or a forced release at MAX_BURST beats), feeding a one-entry output slice.
module r_burst_arbiter #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned DATA_W    = 14,
    parameter int unsigned MAX_BURST = 256
) (
    input  logic                       CLK,
    input  logic                       RESETn,
    r_burst_arbiter_if.slave           bus,
    output logic [$clog2(NUM_SRC)-1:0] GRANT_ID,
    output logic                       BUSY,
    output logic                       OVERRUN
);
    localparam int unsigned ID_W  = $clog2(NUM_SRC);
    localparam int unsigned CNT_W = $clog2(MAX_BURST);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e            r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_grant;
    logic [CNT_W-1:0]  r_bcnt;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              r_valid;
    logic              r_busy;
    logic              r_overrun;

    logic              w_found;
    logic [ID_W-1:0]   w_winner;
    logic [NUM_SRC-1:0] w_ready_out;
    logic              w_accept;
    logic              w_beat_last;
    logic [DATA_W-1:0] w_beat_data;
    logic [ID_W-1:0]   w_next_ptr;

    // First requester at or after the pointer, wrapping modulo NUM_SRC.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            int unsigned idx;
            idx = (32'(r_ptr) + i) % NUM_SRC;
            if (!w_found && bus.VALID_IN[idx]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(idx);
            end
        end
    end

    // Depends only on state, slice occupancy and READY; never on VALID_IN or DATA_IN.
    always_comb begin
        w_ready_out = '0;
        if (r_state == StLock) begin
            w_ready_out[r_grant] = !r_valid || bus.READY;
        end
    end

    assign w_accept    = (r_state == StLock) && bus.VALID_IN[r_grant] && w_ready_out[r_grant];
    assign w_beat_last = bus.LAST_IN[r_grant];
    assign w_beat_data = bus.DATA_IN[32'(r_grant)*DATA_W +: DATA_W];
    assign w_next_ptr  = (r_grant == ID_W'(NUM_SRC - 1)) ? '0 : r_grant + ID_W'(1);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state   <= StIdle;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_bcnt    <= '0;
            r_data    <= '0;
            r_last    <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_accept) begin
                r_data  <= w_beat_data;
                r_last  <= w_beat_last;
                r_valid <= 1'b1;
            end else if (bus.READY) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_state <= StLock;
                        r_grant <= w_winner;
                        r_bcnt  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                StLock: begin
                    if (w_accept) begin
                        r_bcnt <= r_bcnt + CNT_W'(1);
                        // Release on LAST, or force it once the beat limit is reached.
                        if (w_beat_last || r_bcnt == CNT_W'(MAX_BURST - 1)) begin
                            r_state   <= StIdle;
                            r_ptr     <= w_next_ptr;
                            r_busy    <= 1'b0;
                            r_overrun <= !w_beat_last;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.READY_OUT = w_ready_out;
    assign bus.DATA      = r_data;
    assign bus.LAST      = r_last;
    assign bus.VALID     = r_valid;
    assign GRANT_ID      = r_grant;
    assign BUSY          = r_busy;
    assign OVERRUN       = r_overrun;
endmodule

// File: doc/r_burst_arbiter.md
# r_burst_arbiter

Burst-locked round-robin arbiter that shares one AXI4 read-data (R) return path between NUM_SRC slave-side sources. A source is granted for a whole burst, from the first beat through the beat with LAST set, so beats of different bursts never interleave on the output. Beats pass through a one-entry registered output slice. The block replaces per-cycle toggling merge fabrics wherever burst integrity is required.

## Interface
- NUM_SRC, 4: number of requesting sources (2..8).
- DATA_W, 14: width of one beat payload, excluding LAST.
- MAX_BURST, 256: beat limit per grant; a power of two, 2..256.
- CLK  in  1  clock; all state updates on the rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- DATA_IN  in  NUM_SRC*DATA_W  packed payloads; source i occupies bits [i*DATA_W +: DATA_W].
- LAST_IN  in  NUM_SRC  per-source last-beat flag.
- VALID_IN  in  NUM_SRC  per-source valid.
- READY_OUT  out  NUM_SRC  per-source ready; at most one bit set.
- DATA  out  DATA_W  registered output payload.
- LAST  out  1  registered output last flag.
- VALID  out  1  output valid.
- READY  in  1  downstream ready.
- GRANT_ID  out  clog2(NUM_SRC)  index of the locked or last-locked source.
- BUSY  out  1  high while in LOCK.
- OVERRUN  out  1  one-cycle pulse on a forced release at MAX_BURST.

## Operation
- FSM states and register values:
  - IDLE: no source locked; READY_OUT = 0.
  - LOCK: source GRANT_ID is locked.
  - Round-robin pointer PTR (clog2(NUM_SRC) bits): reset 0.
  - Beat counter BCNT (clog2(MAX_BURST) bits): reset 0.
- IDLE → LOCK when any VALID_IN bit is high.
  - The winner is the first set VALID_IN bit scanning PTR, PTR+1, … with wrap modulo NUM_SRC.
  - GRANT_ID is loaded with the winner and BCNT is cleared.
- In LOCK: READY_OUT[GRANT_ID] = !VALID || READY; all other READY_OUT bits are 0.
- Beat accept: VALID_IN[GRANT_ID] && READY_OUT[GRANT_ID].
  - On accept, DATA, LAST and VALID are loaded from source GRANT_ID.
  - On accept, BCNT increments.
- Output slice: VALID clears when READY is high and no new beat is loaded in the same cycle. DATA and LAST hold while VALID && !READY.
- LOCK → IDLE on an accepted beat with LAST_IN set. PTR is set to (GRANT_ID+1) mod NUM_SRC.
- Forced release: an accepted beat without LAST when BCNT == MAX_BURST-1.
  - The FSM goes to IDLE and PTR advances as for a normal release.
  - OVERRUN pulses high for the following cycle. The beat itself is forwarded unchanged.
- A source deasserting VALID mid-burst does not release the lock; the arbiter waits indefinitely.
- VALID_IN bits of non-granted sources are ignored while in LOCK.

## Timing
- Reset values: FSM IDLE, PTR 0, BCNT 0, GRANT_ID 0, DATA 0, LAST 0, VALID 0, BUSY 0, OVERRUN 0, READY_OUT 0.
- Asserting RESETn low mid-burst clears all state immediately. Any beat held in the output slice is discarded.
- Arbitration latency:
  - Request first seen in IDLE at cycle c → LOCK and READY_OUT at cycle c+1.
  - First beat accepted at the end of c+1 → VALID at c+2.
- Throughput is 1 beat/cycle while READY stays high.
- Exactly one IDLE bubble cycle separates consecutive bursts.
- READY_OUT depends combinationally on READY. It has no combinational path from VALID_IN or DATA_IN.
- BUSY is a registered decode of the FSM state.
- When an IDLE arbitration and an output-slice drain fall in the same cycle, both take effect.

## Test plan
- Single source: NUM_SRC=4, source 2 sends a 4-beat burst (payloads 0x11..0x14, LAST on beat 4), READY=1.
  - Required: GRANT_ID=2.
  - VALID high for 4 consecutive cycles starting 2 cycles after the request, LAST only on the 4th beat.
  - PTR becomes 3.
- Contention: sources 0 and 1 each hold a 3-beat burst from cycle 0.
  - Required: all 3 beats of source 0, one bubble, then all 3 beats of source 1.
  - No interleaving, READY_OUT one-hot throughout.
- Round-robin fairness: all 4 sources continuously request 1-beat bursts.
  - Required: grant order 0,1,2,3,0,… with one beat every 2 cycles.
- Backpressure: READY=0 for 5 cycles during a burst from source 3.
  - Required: DATA and LAST stable, READY_OUT[3]=0 while the slice is full.
  - No beat lost or duplicated after READY returns to 1.
- Overrun: MAX_BURST=4, source 1 sends 6 beats with LAST never set.
  - Required: release after beat 4 with an OVERRUN pulse.
  - Source 1 re-arbitrates and beats 5–6 follow in a new grant.
- Reset mid-burst: RESETn low after beat 2 of 4.
  - Required: all outputs at their reset values while RESETn is low.
  - After release, arbitration restarts from PTR 0.
